// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Brief    : Shared encodings for the data-memory access block: access-type
//            (CTL) codes, FSM state encoding and the RAM address width default.
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int AW_DEFAULT = 10;

    // Access-type codes; stores reuse them as 0/1 = sb, 2/3 = sh, 4 = sw
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LBU = 3'd1;
    localparam logic [2:0] LH  = 3'd2;
    localparam logic [2:0] LHU = 3'd3;
    localparam logic [2:0] LW  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    // Byte accesses (and the undefined codes 5-7) never fault on alignment
    function automatic logic is_aligned(input logic [2:0] ctl, input logic [1:0] lo);
        case (ctl)
            LH, LHU: return ~lo[0];
            LW:      return (lo == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/st_merge.sv
`default_nettype none
// ============================================================================
// Module   : st_merge
// Brief    : Combinational store merge. Inserts the byte/halfword of the store
//            data into the old RAM word at the lane picked by addr_lo; a word
//            store passes the store data through unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module st_merge
    import dm_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] st_data_i,
    input  logic [2:0]  ctl_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] merged_o
);

    // Lane insertion: byte lane = addr_lo, half lane = upper only when addr_lo == 2
    always_comb begin
        merged_o = st_data_i;
        case (ctl_i)
            LB, LBU: begin
                merged_o = old_word_i;
                merged_o[{addr_lo_i, 3'b000} +: 8] = st_data_i[7:0];
            end
            LH, LHU: begin
                merged_o = old_word_i;
                if (addr_lo_i == 2'd2) begin
                    merged_o[31:16] = st_data_i[15:0];
                end else begin
                    merged_o[15:0] = st_data_i[15:0];
                end
            end
            default: merged_o = st_data_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_access.sv
`default_nettype none
// ============================================================================
// Module   : dm_access
// Brief    : MEM-stage data-memory access sequencer for a synchronous
//            single-port RAM. Loads read one word; sub-word stores perform a
//            read-modify-write; word stores write directly. All outputs are
//            registered, derived from the next state so they line up with it.
// Revision : 1.0 - initial release
// ============================================================================
module dm_access
    import dm_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [2:0]    CTL,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic [31:0]   worddata,
    output logic [1:0]    addr_lo,
    output logic [2:0]    CTL_out,
    output logic          exc_adel,
    output logic          exc_ades,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  ctl_q;
    logic [1:0]  lo_q;
    logic [31:0] wdata_q;

    logic        w_accept;
    logic        w_misal;
    logic [31:0] w_merged;

    // Address bits above the RAM window are intentionally ignored
    logic        w_unused_addr;
    assign w_unused_addr = ^addr[31:AW+2];

    st_merge u_st_merge (
        .old_word_i (ram_rdata),
        .st_data_i  (wdata_q),
        .ctl_i      (ctl_q),
        .addr_lo_i  (lo_q),
        .merged_o   (w_merged)
    );

    // Next-state: req is only looked at in IDLE, so DONE forces an idle gap
    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        w_misal  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (is_aligned(CTL, addr[1:0])) begin
                        w_accept = 1'b1;
                        if (!we)               state_d = RD;
                        else if (CTL == LW)    state_d = WR;
                        else if (CTL <= LHU)   state_d = RD;
                        else                   state_d = DONE;
                    end else begin
                        w_misal = 1'b1;
                    end
                end
            end
            RD:      state_d = CAP;
            CAP:     state_d = we_q ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, registered outputs, request latch and load/merge capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            ctl_q     <= 3'd0;
            lo_q      <= 2'd0;
            wdata_q   <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            worddata  <= 32'd0;
            addr_lo   <= 2'd0;
            CTL_out   <= 3'd0;
            ram_addr  <= '0;
            ram_wdata <= 32'd0;
        end else begin
            state_q  <= state_d;
            busy     <= (state_d == RD) || (state_d == CAP) || (state_d == WR);
            done     <= (state_d == DONE);
            ram_en   <= (state_d == RD) || (state_d == WR);
            ram_we   <= (state_d == WR);
            exc_adel <= w_misal && !we;
            exc_ades <= w_misal && we;

            if (w_accept) begin
                we_q     <= we;
                ctl_q    <= CTL;
                lo_q     <= addr[1:0];
                wdata_q  <= wdata;
                ram_addr <= addr[AW+1:2];
                if (we && (CTL == LW)) begin
                    ram_wdata <= wdata;
                end
            end

            if (state_q == CAP) begin
                if (!we_q) begin
                    worddata <= ram_rdata;
                    addr_lo  <= lo_q;
                    CTL_out  <= ctl_q;
                end else begin
                    ram_wdata <= w_merged;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dm_access.md
DM_ACCESS -- requirements
Module: dm_access

Interface
REQ-001 The block SHALL have parameter AW, default 10: RAM word-address width (4 KB data memory).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  1  MEM-stage access request, sampled in IDLE only.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 CTL  in  3  access type: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw; stores use 0/1 = sb, 2/3 = sh, 4 = sw.
REQ-007 addr  in  32  byte address.
REQ-008 wdata  in  32  store data, right-justified.
REQ-009 busy  out  1  access in progress; the pipeline stalls while high.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 worddata  out  32  raw aligned load word for the load-extension stage; valid while done is high.
REQ-012 addr_lo  out  2  latched addr[1:0] for the load-extension stage.
REQ-013 CTL_out  out  3  latched CTL for the load-extension stage.
REQ-014 exc_adel / exc_ades  out  1 each  one-cycle misaligned load / store pulse.
REQ-015 ram_en, ram_we  out  1 each  synchronous single-port RAM enable and write enable.
REQ-016 ram_addr  out  AW  equals latched addr[AW+1:2].
REQ-017 ram_wdata  out  32  full write word.
REQ-018 ram_rdata  in  32  RAM read data, valid one cycle after a read-enable edge.

Function
REQ-019 The FSM SHALL have the states IDLE, RD, CAP, WR and DONE; the state register and all outputs SHALL be registered.
REQ-020 In IDLE with req=1 and an aligned access, the block SHALL latch addr, wdata, CTL and we.
REQ-021 After that latch: load → RD; sw → WR; sb/sh → RD; store with CTL 5-7 → DONE with no RAM write.
REQ-022 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned.
REQ-023 On a misaligned req in IDLE, the block SHALL pulse exc_adel (load) or exc_ades (store) the next cycle, stay in IDLE, touch no RAM and not assert done.
REQ-024 In RD, ram_en=1 and ram_we=0; next state is CAP.
REQ-025 In CAP on a load, the block SHALL register worddata <= ram_rdata and go to DONE.
REQ-026 In CAP on sb/sh, the block SHALL merge the byte/half lane selected by addr_lo into ram_rdata and go to WR.
REQ-027 Lane select: byte → lane addr_lo; half → bits [31:16] if addr_lo=2, else [15:0].
REQ-028 In WR, ram_en=1, ram_we=1 and ram_wdata = merged word (sw: wdata unchanged); next state is DONE.
REQ-029 In DONE, done=1 for exactly one cycle and busy=0; next state is IDLE.
REQ-030 busy SHALL be 1 in RD, CAP and WR, and 0 in IDLE and DONE.
REQ-031 Latency from the req cycle T: lw/lb/lh done at T+3; sw done at T+2; sb/sh done at T+4; invalid store done at T+1.
REQ-032 req outside IDLE (including DONE) SHALL be ignored; back-to-back accesses therefore have a minimum one idle cycle.
REQ-033 Load CTL 5-7 SHALL complete normally; the downstream extension stage yields 0.
REQ-034 worddata, addr_lo and CTL_out SHALL hold their values until the next load reaches CAP.

Reset
REQ-035 rst_n=0 SHALL immediately (asynchronously) force state=IDLE and drive busy, done, exc_adel, exc_ades, ram_en and ram_we to 0, and worddata, addr_lo, CTL_out, ram_addr and ram_wdata to 0.
REQ-036 Reset during RD/CAP of a read-modify-write SHALL leave RAM unmodified; reset during WR gives an undefined RAM word at that address only.

Structure
REQ-037 Shared package dm_pkg SHALL hold the CTL encodings (LB, LBU, LH, LHU, LW), the FSM state encoding and the AW default.
REQ-038 Combinational sub-module st_merge SHALL take old word, store data, CTL and addr_lo, and return the merged word.

Verification
REQ-039 sw addr=0x10, wdata=0xDEADBEEF → WR at T+1 with ram_addr=4, ram_wdata=0xDEADBEEF; done at T+2.
REQ-040 RAM[4]=0xDEADBEEF; sb addr=0x12, wdata=0x55 → RD, then WR of 0xDE55BEEF; done at T+4.
REQ-041 RAM[4]=0xDE55BEEF; lh addr=0x12, CTL=2 → done at T+3, worddata=0xDE55BEEF, addr_lo=2, CTL_out=2.
REQ-042 lw addr=0x13 → exc_adel pulse at T+1, no ram_en, no done, busy stays 0; sh addr=0x11 → exc_ades pulse.
REQ-043 req held high across an lw → exactly one access; second accepted only after DONE→IDLE (done at T+3, T+7).
REQ-044 rst_n low during CAP of sb → ram_we never asserted, outputs 0, RAM[4] unchanged; next lw reads original value.
